// File: rtl/data_serializer.sv
// data_serializer: parallel-to-serial converter, LSB first.
// A word is captured from DataIn when load is seen in IDLE. Its bits are then
// presented one at a time on BitOut, and the consumer acknowledges each bit
// with shiftEn. A single-cycle Done pulse follows the final acknowledged bit.
//
// Handshake: while BitValid=1, BitOut and LastBit are stable. They advance
// only on a rising edge where shiftEn=1, which means "this bit was taken".
// load is a request that is only honoured on an edge where Ready=1. A load
// made at any other time is dropped, not deferred. No output depends on
// load or shiftEn combinationally. Every output comes from the state
// register, the shift register or the remaining-bit counter.
module data_serializer #(
  parameter int DATAWIDTH = 8,
  parameter int CW        = $clog2(DATAWIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] DataIn,
  input  logic                 shiftEn,
  output logic                 Ready,
  output logic                 BitOut,
  output logic                 BitValid,
  output logic                 LastBit,
  output logic                 Done,
  output logic [CW-1:0]        Remaining
);

  // Encoding 2'd3 is unused. The next-state logic steers it back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] REM_FULL = CW'(DATAWIDTH);
  localparam logic [CW-1:0] REM_ONE  = CW'(1);
  localparam logic [CW-1:0] REM_ZERO = '0;

  // state_q is the FSM state exposed for checkers and debug binding.
  state_t               state_q;
  state_t               state_d;
  logic [DATAWIDTH-1:0] sreg_q;
  logic [CW-1:0]        rem_q;
  logic                 on_last;
  logic                 take_bit;

  // Condition flags shared by the next-state and datapath logic.
  assign on_last  = (rem_q == REM_ONE);
  assign take_bit = (state_q == SHIFT) && shiftEn;

  // State register. Reset has priority, so a load in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. DONE lasts exactly one cycle. Unused codes recover to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = load ? SHIFT : IDLE;
      SHIFT:   state_d = (shiftEn && on_last) ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture in IDLE and shift/count on each acknowledge in SHIFT.
  // Everything else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      rem_q  <= REM_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            sreg_q <= DataIn;
            rem_q  <= REM_FULL;
          end
        end
        SHIFT: begin
          if (take_bit) begin
            sreg_q <= {1'b0, sreg_q[DATAWIDTH-1:1]};
            // The guard keeps the counter from wrapping below zero.
            if (rem_q != REM_ZERO) begin
              rem_q <= rem_q - REM_ONE;
            end
          end
        end
        DONE: begin
          sreg_q <= sreg_q;
          rem_q  <= rem_q;
        end
        default: begin
          // Leftover contents from a corrupted state are cleared during recovery.
          sreg_q <= '0;
          rem_q  <= REM_ZERO;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    Ready    = 1'b0;
    BitOut   = 1'b0;
    BitValid = 1'b0;
    LastBit  = 1'b0;
    Done     = 1'b0;
    case (state_q)
      IDLE: begin
        Ready = 1'b1;
      end
      SHIFT: begin
        BitValid = 1'b1;
        BitOut   = sreg_q[0];
        LastBit  = on_last;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
        Ready = 1'b0;
      end
    endcase
  end

  assign Remaining = rem_q;

endmodule

// File: tb/tb_data_serializer.sv
// Bench for data_serializer. It uses an 8-bit instance for most scenarios and
// a 2-bit instance for the narrow-width corner. Expected bits come from a queue
// that is filled LSB first from the loaded word. The queue is popped on each
// acknowledged bit.
module tb_data_serializer;

  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int W2  = 2;
  localparam int CW2 = 2;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, load, shift_en;
  logic [W-1:0]  din;
  logic          ready, bit_out, bit_valid, last_bit, done;
  logic [CW-1:0] remaining;

  logic           rst2, load2, shift_en2;
  logic [W2-1:0]  din2;
  logic           ready2, bit_out2, bit_valid2, last_bit2, done2;
  logic [CW2-1:0] remaining2;

  int checks = 0;
  int errors = 0;

  logic [0:0] exp_q[$];

  data_serializer #(.DATAWIDTH(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .load(load), .DataIn(din), .shiftEn(shift_en),
    .Ready(ready), .BitOut(bit_out), .BitValid(bit_valid), .LastBit(last_bit),
    .Done(done), .Remaining(remaining)
  );

  data_serializer #(.DATAWIDTH(W2), .CW(CW2)) dut2 (
    .clk(clk), .rst(rst2), .load(load2), .DataIn(din2), .shiftEn(shift_en2),
    .Ready(ready2), .BitOut(bit_out2), .BitValid(bit_valid2), .LastBit(last_bit2),
    .Done(done2), .Remaining(remaining2)
  );

  // driver: advance one edge, then settle away from it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; din = 8'h3C; shift_en = 1'b1;
    rst2 = 1'b1; load2 = 1'b1; din2 = 2'b11; shift_en2 = 1'b1;
    tick(); tick();
    checks++;
    if ({ready, bit_out, bit_valid, last_bit, done, remaining} !== {1'b1, 4'b0000, 4'd0}) begin
      errors++;
      $display("FAIL reset8: got rdy/bo/bv/lb/dn/rem=%b required 100000000",
               {ready, bit_out, bit_valid, last_bit, done, remaining});
    end
    checks++;
    if ({ready2, bit_out2, bit_valid2, last_bit2, done2, remaining2} !== {1'b1, 4'b0000, 2'd0}) begin
      errors++;
      $display("FAIL reset2: got %b required 1000000",
               {ready2, bit_out2, bit_valid2, last_bit2, done2, remaining2});
    end
    rst = 1'b0; load = 1'b0; rst2 = 1'b0; load2 = 1'b0; shift_en2 = 1'b0;
    // shiftEn in IDLE must not disturb anything
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({ready, bit_valid, done, remaining} !== {1'b1, 2'b00, 4'd0}) begin
      errors++;
      $display("FAIL idle_shiften: got rdy/bv/dn/rem=%b required 1000000",
               {ready, bit_valid, done, remaining});
    end
    shift_en = 1'b0;
    // first bit appears one edge after load, with the full count
    din = 8'hB6; load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if ({ready, bit_valid, bit_out, last_bit, remaining} !== {4'b0100, 4'd8}) begin
      errors++;
      $display("FAIL load_latency: got rdy/bv/bo/lb/rem=%b required 01001000",
               {ready, bit_valid, bit_out, last_bit, remaining});
    end
    // drain this word before the next scenario
    shift_en = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    shift_en = 1'b0;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_ready: got %b required 1", ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] data;
    data = 8'hA5;
    din = data; load = 1'b1; shift_en = 1'b1;
    tick();
    load = 1'b0;
    // observation c is c edges after the load edge; Done lands on c=9,
    // which is the tenth cycle when the load cycle counts as the first
    for (int c = 1; c <= 12; c++) begin
      logic [3:0] exp_v;
      exp_v = {(c <= 8), (c == 8), (c == 9), (c >= 10)};
      checks++;
      if ({bit_valid, last_bit, done, ready} !== exp_v) begin
        errors++;
        $display("FAIL basic_ctrl c=%0d: got bv/lb/dn/rdy=%b required %b",
                 c, {bit_valid, last_bit, done, ready}, exp_v);
      end
      if (c <= 8) begin
        checks++;
        if (bit_out !== data[c-1]) begin
          errors++;
          $display("FAIL basic_bit c=%0d: got %b required %b", c, bit_out, data[c-1]);
        end
      end
      tick();
    end
    shift_en = 1'b0;
  endtask

  task automatic test_stall();
    logic p[4];
    logic [W-1:0] got;
    int n_got, n_done, idx;
    p = '{1'b1, 1'b0, 1'b0, 1'b1};
    got = '0; n_got = 0; n_done = 0; idx = 0;
    din = 8'h81; load = 1'b1; shift_en = 1'b0;
    tick();
    load = 1'b0;
    exp_q.delete();
    for (int b = 0; b < W; b++) exp_q.push_back(din[b]);
    for (int c = 0; c < 40; c++) begin
      logic se, was_valid;
      if (done === 1'b1) n_done++;
      was_valid = bit_valid;
      if (bit_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0 || bit_out !== exp_q[0] || remaining !== CW'(exp_q.size())) begin
          errors++;
          $display("FAIL stall_bit c=%0d: got bo=%b rem=%0d required bo=%b rem=%0d",
                   c, bit_out, remaining, (exp_q.size() > 0) ? exp_q[0] : 1'bx, exp_q.size());
        end
      end
      se = p[idx % 4];
      idx++;
      shift_en = se;
      if (se && was_valid === 1'b1 && n_got < W) begin
        got[n_got] = bit_out;
        n_got++;
      end
      tick();
      if (se && was_valid === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    shift_en = 1'b0;
    checks++;
    if (n_got != W || got !== 8'h81) begin
      errors++;
      $display("FAIL stall_seq: got %0d bits %b required 8 bits 10000001", n_got, got);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL stall_done: got %0d pulses required 1", n_done);
    end
  endtask

  task automatic test_ignored_load();
    int injected, seen_done, post_done;
    injected = 0; seen_done = 0; post_done = 0;
    din = 8'hFF; load = 1'b1; shift_en = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 20 && post_done == 0; c++) begin
      if (seen_done == 1) begin
        post_done = 1;
        checks++;
        if ({ready, bit_valid, remaining} !== {2'b10, 4'd0}) begin
          errors++;
          $display("FAIL ign_after_done: got rdy/bv/rem=%b required 100000",
                   {ready, bit_valid, remaining});
        end
      end else begin
        checks++;
        if (ready !== 1'b0 || (bit_valid === 1'b1 && bit_out !== 1'b1)) begin
          errors++;
          $display("FAIL ign_word c=%0d: got rdy=%b bo=%b required rdy=0 bo=1", c, ready, bit_out);
        end
        if (done === 1'b1) seen_done = 1;
        load = 1'b0;
        if (bit_valid === 1'b1 && remaining === 4'd5 && injected == 0) begin
          load = 1'b1; din = 8'h00; injected = 1;
        end
        tick();
      end
    end
    load = 1'b0; shift_en = 1'b0;
    checks++;
    if (injected != 1 || post_done != 1) begin
      errors++;
      $display("FAIL ign_flow: got injected=%0d done_seen=%0d required 1 1", injected, post_done);
    end
  endtask

  task automatic test_mid_reset();
    int found, n_done;
    found = 0; n_done = 0;
    din = 8'h5A; load = 1'b1; shift_en = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (remaining === 4'd3) found = 1;
      else tick();
    end
    checks++;
    if (found != 1) begin
      errors++;
      $display("FAIL midrst_reach: got no Remaining==3 required reached");
    end
    // a load in the reset cycle must also be discarded
    rst = 1'b1; load = 1'b1; din = 8'hFF;
    tick();
    rst = 1'b0; load = 1'b0;
    checks++;
    if ({ready, remaining, bit_valid, done} !== {1'b1, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL midrst_state: got rdy/rem/bv/dn=%b required 1000000",
               {ready, remaining, bit_valid, done});
    end
    for (int c = 0; c < 15; c++) begin
      if (done === 1'b1 || ready !== 1'b1) n_done++;
      tick();
    end
    shift_en = 1'b0;
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL midrst_nodone: got %0d bad cycles required 0", n_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    int n_got, n_done, gap, gap_done, gap_ready, second;
    got = '0; n_got = 0; n_done = 0; gap = 0; gap_done = 0; gap_ready = 0; second = 0;
    din = 8'h0F; load = 1'b1; shift_en = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 40 && n_done < 2; c++) begin
      if (bit_valid === 1'b1 && n_got < 16) begin
        got[n_got] = bit_out;
        n_got++;
      end else if (n_got == 8) begin
        gap++;
        if (done === 1'b1) gap_done++;
        if (ready === 1'b1) gap_ready++;
      end
      if (done === 1'b1) n_done++;
      load = 1'b0;
      if (n_done == 1 && ready === 1'b1 && second == 0) begin
        load = 1'b1; din = 8'hF0; second = 1;
      end
      tick();
    end
    load = 1'b0; shift_en = 1'b0;
    checks++;
    if (n_got != 16 || got !== {8'hF0, 8'h0F}) begin
      errors++;
      $display("FAIL b2b_stream: got %0d bits %h required 16 bits f00f", n_got, got);
    end
    checks++;
    if (gap != 2 || gap_done != 1 || gap_ready != 1) begin
      errors++;
      $display("FAIL b2b_gap: got gap=%0d done=%0d ready=%0d required 2 1 1", gap, gap_done, gap_ready);
    end
  endtask

  task automatic test_width2();
    din2 = 2'b10; load2 = 1'b1; shift_en2 = 1'b1;
    tick();
    load2 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      logic [4:0] exp_v, obs;
      // bit_out only meaningful when valid, so mask it otherwise
      obs = {bit_valid2, bit_valid2 & bit_out2, last_bit2, done2, ready2};
      case (c)
        1: exp_v = 5'b10000;
        2: exp_v = 5'b11100;
        3: exp_v = 5'b00010;
        default: exp_v = 5'b00001;
      endcase
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL width2 c=%0d: got bv/bo/lb/dn/rdy=%b required %b", c, obs, exp_v);
      end
      tick();
    end
    shift_en2 = 1'b0;
  endtask

  task automatic test_random();
    for (int w = 0; w < 30; w++) begin
      logic [W-1:0] data;
      int budget;
      data = W'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        shift_en = 1'($urandom_range(0, 1));
        tick();
      end
      checks++;
      if ({ready, bit_valid, last_bit, done, remaining} !== {4'b1000, 4'd0}) begin
        errors++;
        $display("FAIL rnd_idle w=%0d: got rdy/bv/lb/dn/rem=%b required 10000000",
                 w, {ready, bit_valid, last_bit, done, remaining});
      end
      din = data; load = 1'b1; shift_en = 1'($urandom_range(0, 1));
      tick();
      load = 1'b0;
      exp_q.delete();
      for (int b = 0; b < W; b++) exp_q.push_back(data[b]);
      budget = 0;
      while (exp_q.size() > 0 && budget < 200) begin
        logic se;
        checks++;
        if ({ready, bit_valid, bit_out, last_bit, done, remaining} !==
            {2'b01, exp_q[0], (exp_q.size() == 1), 1'b0, CW'(exp_q.size())}) begin
          errors++;
          $display("FAIL rnd_shift w=%0d: got rdy/bv/bo/lb/dn/rem=%b required bo=%b rem=%0d",
                   w, {ready, bit_valid, bit_out, last_bit, done, remaining}, exp_q[0], exp_q.size());
        end
        se = 1'($urandom_range(0, 1));
        shift_en = se;
        load = ($urandom_range(0, 3) == 0);
        din = W'($urandom);
        tick();
        if (se) void'(exp_q.pop_front());
        budget++;
      end
      load = 1'b0;
      if (budget >= 200) begin
        errors++;
        $display("FAIL rnd_budget w=%0d: got %0d bits left required 0", w, exp_q.size());
      end
      checks++;
      if ({ready, bit_valid, done, remaining} !== {3'b001, 4'd0}) begin
        errors++;
        $display("FAIL rnd_done w=%0d: got rdy/bv/dn/rem=%b required 0010000",
                 w, {ready, bit_valid, done, remaining});
      end
      // stray load and shiftEn in DONE must be dropped
      load = 1'($urandom_range(0, 1)); din = W'($urandom); shift_en = 1'($urandom_range(0, 1));
      tick();
      load = 1'b0;
    end
    shift_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_ignored_load();
    test_mid_reset();
    test_back_to_back();
    test_width2();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got no completion required finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/data_serializer.md
DATA_SERIALIZER -- requirements
Module: data_serializer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the parallel word width; legal values are 2..32.
REQ-002 The block SHALL have parameter CW, default $clog2(DATAWIDTH+1), giving the width of the remaining-bit counter.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: a synchronous, active-high reset.
REQ-005 Port load SHALL be an input, 1 bit wide: a request to capture DataIn; honoured only when Ready=1.
REQ-006 Port DataIn SHALL be an input, DATAWIDTH bits wide: the parallel word to serialize.
REQ-007 Port shiftEn SHALL be an input, 1 bit wide: a consumer acknowledge that advances one bit.
REQ-008 Port Ready SHALL be an output, 1 bit wide: high when the block can accept a load.
REQ-009 Port BitOut SHALL be an output, 1 bit wide: the current serial bit, LSB first.
REQ-010 Port BitValid SHALL be an output, 1 bit wide: high when BitOut is meaningful.
REQ-011 Port LastBit SHALL be an output, 1 bit wide: high when BitOut is the final bit of the word.
REQ-012 Port Done SHALL be an output, 1 bit wide: a one-cycle pulse after the final bit is consumed.
REQ-013 Port Remaining SHALL be an output, CW bits wide: the number of bits not yet consumed.

Function
REQ-014 The block SHALL implement an FSM with exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, the block SHALL drive Ready=1, BitValid=0, LastBit=0 and Done=0.
REQ-016 In IDLE with load=1, the shift register SHALL capture DataIn and Remaining SHALL become DATAWIDTH on the next edge, with the state moving to SHIFT.
REQ-017 Load-to-first-BitValid latency SHALL be exactly 1 cycle.
REQ-018 In SHIFT, the block SHALL drive Ready=0, BitValid=1 and BitOut=shift register bit 0.
REQ-019 In SHIFT, LastBit SHALL be 1 exactly when Remaining==1.
REQ-020 In SHIFT with shiftEn=1, the shift register SHALL shift right one position, zero-filling the MSB.
REQ-021 In SHIFT with shiftEn=1, Remaining SHALL decrement by 1 on the same edge.
REQ-022 In SHIFT with shiftEn=0, all state SHALL hold, so BitOut and Remaining stay stable with no timeout.
REQ-023 In SHIFT with shiftEn=1 and Remaining==1, the next state SHALL be DONE and Remaining SHALL become 0.
REQ-024 In DONE, the block SHALL drive Done=1, Ready=0 and BitValid=0 for exactly one cycle, then return unconditionally to IDLE.
REQ-025 A load asserted in SHIFT or DONE SHALL be ignored without being queued, and the word in flight SHALL be unaffected.
REQ-026 A shiftEn asserted in IDLE or DONE SHALL be ignored, with no change to Remaining or the shift register.
REQ-027 Back-to-back operation SHALL be supported: a load in the IDLE cycle following DONE starts a new word, so the minimum word period is DATAWIDTH+2 cycles when shiftEn is held at 1.
REQ-028 Remaining SHALL never underflow below 0 and never exceed DATAWIDTH.
REQ-029 All outputs SHALL be derived from registered state; there SHALL be no combinational path from load or shiftEn to any output.
REQ-030 The FSM SHALL recover to IDLE on the next edge from any unused state encoding.

Reset
REQ-031 With rst=1 at a rising edge, the block SHALL enter IDLE and clear the shift register and Remaining to 0, regardless of load or shiftEn.
REQ-032 The reset values of the outputs SHALL be Ready=1, BitOut=0, BitValid=0, LastBit=0, Done=0 and Remaining=0.
REQ-033 Reset asserted mid-SHIFT SHALL abort the word, and no Done pulse SHALL be produced for it.
REQ-034 A load asserted in the same cycle as rst SHALL be discarded.

Verification
REQ-035 Basic serialization: with DATAWIDTH=8, load 8'hA5 and hold shiftEn=1 -> BitOut = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, LastBit=1 only on the 8th, and Done pulses on cycle 10 counted from the load edge.
REQ-036 Stalls: load 8'h81, then toggle shiftEn 1,0,0,1,... -> BitOut and Remaining hold during the 0 cycles, the full sequence is 1,0,0,0,0,0,0,1, and there is exactly one Done pulse.
REQ-037 Ignored load: load 8'hFF, then assert load with 8'h00 at Remaining==5 -> the remaining bits are still all 1, and Ready stays 0 until after Done.
REQ-038 Mid-operation reset: assert rst with Remaining==3 -> the next cycle shows Ready=1, Remaining=0, BitValid=0, and no Done pulse ever appears.
REQ-039 Back-to-back words: load 8'h0F, then load 8'hF0 in the first IDLE cycle after Done -> 16 valid bits 1111000000001111 with a 2-cycle gap containing Done and Ready.
REQ-040 Width corner: with DATAWIDTH=2, load 2'b10 -> BitOut=0 with LastBit=0, then BitOut=1 with LastBit=1, then Done.
